// File: rtl/keypad_event_controller.sv
// keypad_event_controller
//
// Purpose:
//   Turns the raw per-scan key snapshots of the keypad scanner into a stream
//   of debounced press/release events. Each key change that survives the
//   debounce count marks the key as pending. An encoder drains the pending
//   keys one per cycle, lowest index first, with presses ahead of releases.
//   The events are queued in a FIFO that software drains through a small
//   Avalon-MM register window. A level interrupt flags queued events or an
//   overflow.
//
// Ports:
//   csi_clock_clk      single clock
//   csi_clock_reset    asynchronous, active-high reset
//   scan_state         raw scanner snapshot, 1 = pressed (NUM_KEYS wide)
//   scan_done          one-cycle strobe, scan_state valid this cycle
//   avs_s0_write       Avalon write strobe
//   avs_s0_read        Avalon read strobe
//   avs_s0_address     register select: 0 CTRL, 1 STATUS, 2 EVENT, 3 STABLE
//   avs_s0_writedata   Avalon write data
//   avs_s0_readdata    registered read data, held until the next read
//   avs_s0_interrupt   registered level interrupt
//
// Optional feature (compile-time macro KEYPAD_EVT_TIMESTAMP_EN):
//   When defined, a 16-bit counter of scan_done strobes is sampled when a scan
//   is accepted and stored with each event, reading back in EVENT bits[23:8].
//   When undefined, those bits read 0 and no counter exists.

module keypad_event_controller #(
   parameter int NUM_KEYS   = 16,
   parameter int FIFO_DEPTH = 16,
   parameter int DEB_W      = 4
) (
   input  logic                csi_clock_clk,
   input  logic                csi_clock_reset,
   input  logic [NUM_KEYS-1:0] scan_state,
   input  logic                scan_done,
   input  logic                avs_s0_write,
   input  logic                avs_s0_read,
   input  logic [1:0]          avs_s0_address,
   input  logic [31:0]         avs_s0_writedata,
   output logic [31:0]         avs_s0_readdata,
   output logic                avs_s0_interrupt
);

   localparam int AW = $clog2(FIFO_DEPTH);
`ifdef KEYPAD_EVT_TIMESTAMP_EN
   localparam int EW = 25;
`else
   localparam int EW = 9;
`endif
   localparam logic [AW:0] DEPTH_L = (AW+1)'(FIFO_DEPTH);

   logic                r_irqEn;
   logic                r_relEn;
   logic [DEB_W-1:0]    r_debCnt;
   logic [NUM_KEYS-1:0] r_candidate;
   logic [DEB_W-1:0]    r_cnt;
   logic [NUM_KEYS-1:0] r_stable;
   logic [NUM_KEYS-1:0] r_pendPress;
   logic [NUM_KEYS-1:0] r_pendRel;
   logic [EW-1:0]       r_mem [FIFO_DEPTH];
   logic [AW:0]         r_wrPtr;
   logic [AW:0]         r_rdPtr;
   logic                r_overflow;
   logic                r_irq;
   logic [31:0]         r_readData;

   logic [NUM_KEYS-1:0] w_candNext;
   logic [DEB_W-1:0]    w_cntNext;
   logic [DEB_W-1:0]    w_debMin;
   logic                w_accept;
   logic [NUM_KEYS-1:0] w_accPress;
   logic [NUM_KEYS-1:0] w_accRel;
   logic [NUM_KEYS-1:0] w_onePress;
   logic [NUM_KEYS-1:0] w_oneRel;
   logic [7:0]          w_pressIdx;
   logic [7:0]          w_relIdx;
   logic                w_emitPress;
   logic                w_emit;
   logic [7:0]          w_emitIdx;
   logic [NUM_KEYS-1:0] w_clrPress;
   logic [NUM_KEYS-1:0] w_clrRel;
   logic [EW-1:0]       w_entry;
   logic [EW-1:0]       w_front;
   logic [AW:0]         w_level;
   logic                w_empty;
   logic                w_full;
   logic                w_ctrlWr;
   logic                w_flush;
   logic                w_statClr;
   logic                w_pop;
   logic                w_push;
   logic                w_drop;
   logic [31:0]         w_ctrlWord;
   logic [31:0]         w_statusWord;
   logic [31:0]         w_eventWord;
   logic [NUM_KEYS+31:0] w_stablePad;
   logic                w_unusedWdata;

   assign w_unusedWdata = ^avs_s0_writedata;

   assign w_level   = r_wrPtr - r_rdPtr;
   assign w_empty   = (w_level == '0);
   assign w_full    = (w_level == DEPTH_L);
   assign w_ctrlWr  = avs_s0_write && (avs_s0_address == 2'd0);
   assign w_flush   = w_ctrlWr && avs_s0_writedata[31];
   assign w_statClr = avs_s0_write && (avs_s0_address == 2'd1) && avs_s0_writedata[2];
   assign w_pop     = avs_s0_read && (avs_s0_address == 2'd2) && !w_empty;

   // Debounce next-state: a snapshot differing from the candidate restarts the
   // count at 1, a repeat of the candidate counts up and saturates. A zero
   // threshold behaves as one so a change can be accepted on its first scan.
   always_comb begin
      w_candNext = r_candidate;
      w_cntNext  = r_cnt;
      if (scan_state != r_candidate) begin
         w_candNext = scan_state;
         w_cntNext  = DEB_W'(1);
      end else if (!(&r_cnt)) begin
         w_cntNext = r_cnt + DEB_W'(1);
      end
   end

   assign w_debMin   = (r_debCnt == '0) ? DEB_W'(1) : r_debCnt;
   assign w_accept   = scan_done && (w_cntNext >= w_debMin) && (w_candNext != r_stable);
   assign w_accPress = w_accept ? (w_candNext & ~r_stable) : '0;
   assign w_accRel   = (w_accept && r_relEn) ? (r_stable & ~w_candNext) : '0;

   // Isolating the lowest set bit with x & -x gives the one-hot key to clear,
   // then the loop only has to translate that one-hot into an index.
   assign w_onePress = r_pendPress & (~r_pendPress + NUM_KEYS'(1));
   assign w_oneRel   = r_pendRel & (~r_pendRel + NUM_KEYS'(1));

   always_comb begin
      w_pressIdx = '0;
      w_relIdx   = '0;
      for (int i = 0; i < NUM_KEYS; i++) begin
         if (w_onePress[i]) w_pressIdx = 8'(i);
         if (w_oneRel[i])   w_relIdx   = 8'(i);
      end
   end

   assign w_emitPress = |r_pendPress;
   assign w_emit      = w_emitPress || (|r_pendRel);
   assign w_emitIdx   = w_emitPress ? w_pressIdx : w_relIdx;
   assign w_clrPress  = w_onePress;
   assign w_clrRel    = w_emitPress ? '0 : w_oneRel;

   // A flush discards whatever the encoder offers in the same cycle; otherwise
   // a full FIFO only accepts the event when a pop frees a slot on that edge.
   assign w_push = w_emit && !w_flush && (!w_full || w_pop);
   assign w_drop = w_emit && !w_flush && w_full && !w_pop;

`ifdef KEYPAD_EVT_TIMESTAMP_EN
   logic [15:0] r_tsCnt;
   logic [15:0] r_acceptTs;

   // Scan counter and the stamp of the most recent accepted scan. Pending keys
   // normally drain long before the next scan, so every event leaving the
   // encoder belongs to the last accept.
   always_ff @(posedge csi_clock_clk or posedge csi_clock_reset) begin
      if (csi_clock_reset) begin
         r_tsCnt    <= '0;
         r_acceptTs <= '0;
      end else begin
         if (scan_done) r_tsCnt    <= r_tsCnt + 16'd1;
         if (w_accept)  r_acceptTs <= r_tsCnt;
      end
   end

   assign w_entry     = {r_acceptTs, w_emitPress, w_emitIdx};
   assign w_front     = r_mem[r_rdPtr[AW-1:0]];
   assign w_eventWord = {1'b1, w_front[8], 6'd0, w_front[24:9], w_front[7:0]};
`else
   assign w_entry     = {w_emitPress, w_emitIdx};
   assign w_front     = r_mem[r_rdPtr[AW-1:0]];
   assign w_eventWord = {1'b1, w_front[8], 22'd0, w_front[7:0]};
`endif

   // Register read views; CTRL bit31 is a command and always reads back 0.
   always_comb begin
      w_ctrlWord                 = '0;
      w_ctrlWord[0]              = r_irqEn;
      w_ctrlWord[1]              = r_relEn;
      w_ctrlWord[4 +: DEB_W]     = r_debCnt;
   end

   assign w_statusWord = {16'd0, 8'(w_level), 5'd0, r_overflow, w_full, w_empty};
   assign w_stablePad  = {32'd0, r_stable};

   // Software configuration register.
   always_ff @(posedge csi_clock_clk or posedge csi_clock_reset) begin
      if (csi_clock_reset) begin
         r_irqEn  <= 1'b0;
         r_relEn  <= 1'b0;
         r_debCnt <= '0;
      end else if (w_ctrlWr) begin
         r_irqEn  <= avs_s0_writedata[0];
         r_relEn  <= avs_s0_writedata[1];
         r_debCnt <= avs_s0_writedata[4 +: DEB_W];
      end
   end

   // Debounce state only moves on scan strobes.
   always_ff @(posedge csi_clock_clk or posedge csi_clock_reset) begin
      if (csi_clock_reset) begin
         r_candidate <= '0;
         r_cnt       <= '0;
         r_stable    <= '0;
      end else if (scan_done) begin
         r_candidate <= w_candNext;
         r_cnt       <= w_cntNext;
         if (w_accept) r_stable <= w_candNext;
      end
   end

   // Pending key sets: the encoder clears one bit per cycle, but a fresh
   // accept of the same key is ORed in afterwards so it is never lost.
   always_ff @(posedge csi_clock_clk or posedge csi_clock_reset) begin
      if (csi_clock_reset) begin
         r_pendPress <= '0;
         r_pendRel   <= '0;
      end else if (w_flush) begin
         r_pendPress <= '0;
         r_pendRel   <= '0;
      end else begin
         r_pendPress <= (r_pendPress & ~w_clrPress) | w_accPress;
         r_pendRel   <= (r_pendRel & ~w_clrRel) | w_accRel;
      end
   end

   // FIFO pointers carry one extra wrap bit so full and empty are distinct.
   always_ff @(posedge csi_clock_clk or posedge csi_clock_reset) begin
      if (csi_clock_reset) begin
         r_wrPtr <= '0;
         r_rdPtr <= '0;
      end else if (w_flush) begin
         r_wrPtr <= '0;
         r_rdPtr <= '0;
      end else begin
         if (w_push) r_wrPtr <= r_wrPtr + 1'b1;
         if (w_pop)  r_rdPtr <= r_rdPtr + 1'b1;
      end
   end

   // Event storage needs no reset: the pointers alone decide what is valid.
   always_ff @(posedge csi_clock_clk) begin
      if (w_push) r_mem[r_wrPtr[AW-1:0]] <= w_entry;
   end

   // Sticky overflow; a newly dropped event outranks a simultaneous W1C.
   always_ff @(posedge csi_clock_clk or posedge csi_clock_reset) begin
      if (csi_clock_reset) begin
         r_overflow <= 1'b0;
      end else if (w_flush) begin
         r_overflow <= 1'b0;
      end else if (w_drop) begin
         r_overflow <= 1'b1;
      end else if (w_statClr) begin
         r_overflow <= 1'b0;
      end
   end

   // Read data is captured on the read strobe and held until the next read.
   always_ff @(posedge csi_clock_clk or posedge csi_clock_reset) begin
      if (csi_clock_reset) begin
         r_readData <= '0;
      end else if (avs_s0_read) begin
         case (avs_s0_address)
            2'd0:    r_readData <= w_ctrlWord;
            2'd1:    r_readData <= w_statusWord;
            2'd2:    r_readData <= w_empty ? 32'd0 : w_eventWord;
            default: r_readData <= w_stablePad[31:0];
         endcase
      end
   end

   // Interrupt is a registered view of the current queue/overflow state.
   always_ff @(posedge csi_clock_clk or posedge csi_clock_reset) begin
      if (csi_clock_reset) begin
         r_irq <= 1'b0;
      end else begin
         r_irq <= r_irqEn && (!w_empty || r_overflow);
      end
   end

   assign avs_s0_readdata  = r_readData;
   assign avs_s0_interrupt = r_irq;

endmodule

// File: tb/tb_keypad_event_controller.sv
// tb_keypad_event_controller
//
// Bench for keypad_event_controller with the default parameters
// (16 keys, 16-entry FIFO, 4-bit debounce count). A behavioural model built
// from bit vectors and a queue of event words predicts readdata and the
// interrupt every cycle; directed scenarios add hand-computed expectations,
// then a randomized phase mixes scans and bus traffic.

module tb_keypad_event_controller;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [15:0] scan_state = '0;
   logic        scan_done = 1'b0;
   logic        wr = 1'b0;
   logic        rd = 1'b0;
   logic [1:0]  addr = '0;
   logic [31:0] wdata = '0;
   logic [31:0] rdata;
   logic        irq;

   int          nAssert = 0;
   int          nFail = 0;
   bit          chkOn = 1'b0;
   logic [15:0] curScan = '0;

   bit [15:0]   mStable, mCand, mPendP, mPendR;
   int          mCnt;
   bit [3:0]    mDeb;
   bit          mIrqEn, mRelEn, mOvf, mIrq;
   bit [31:0]   mRd;
   bit [31:0]   mQ[$];

   keypad_event_controller #(
      .NUM_KEYS  (16),
      .FIFO_DEPTH(16),
      .DEB_W     (4)
   ) dut (
      .csi_clock_clk   (clk),
      .csi_clock_reset (rst),
      .scan_state      (scan_state),
      .scan_done       (scan_done),
      .avs_s0_write    (wr),
      .avs_s0_read     (rd),
      .avs_s0_address  (addr),
      .avs_s0_writedata(wdata),
      .avs_s0_readdata (rdata),
      .avs_s0_interrupt(irq)
   );

   always #5 clk = ~clk;

   function automatic int lowestBit(input bit [15:0] v);
      for (int i = 0; i < 16; i++) begin
         if (v[i]) return i;
      end
      return -1;
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      nAssert++;
      if (act !== exp) begin
         nFail++;
         $display("[TB] FAIL %s: actual=%h required=%h", name, act, exp);
      end
   endtask

   // Reference model: advances once per clock edge from the inputs the DUT
   // saw on that edge, following the register map and event rules directly.
   always @(posedge clk or posedge rst) begin : model
      int        k;
      int        oldSize;
      int        thr;
      bit        popped, emit, flush, nextIrq;
      bit [31:0] word;
      if (rst) begin
         mStable = '0; mCand = '0; mPendP = '0; mPendR = '0; mCnt = 0;
         mDeb = '0; mIrqEn = 0; mRelEn = 0; mOvf = 0; mIrq = 0; mRd = '0;
         mQ.delete();
      end else begin
         nextIrq = mIrqEn && ((mQ.size() != 0) || mOvf);
         popped  = 0;
         if (rd) begin
            case (addr)
               2'd0: mRd = {24'd0, mDeb, 2'b00, mRelEn, mIrqEn};
               2'd1: mRd = {16'd0, 8'(mQ.size()), 5'd0, mOvf, 1'(mQ.size() == 16), 1'(mQ.size() == 0)};
               2'd2: begin
                  if (mQ.size() != 0) begin
                     mRd = mQ[0];
                     popped = 1;
                  end else begin
                     mRd = '0;
                  end
               end
               default: mRd = {16'd0, mStable};
            endcase
         end
         emit = 0;
         word = '0;
         k = lowestBit(mPendP);
         if (k >= 0) begin
            word = 32'hC000_0000 | k;
            mPendP[k] = 1'b0;
            emit = 1;
         end else begin
            k = lowestBit(mPendR);
            if (k >= 0) begin
               word = 32'h8000_0000 | k;
               mPendR[k] = 1'b0;
               emit = 1;
            end
         end
         if (scan_done) begin
            if (scan_state != mCand) begin
               mCand = scan_state;
               mCnt  = 1;
            end else if (mCnt < 15) begin
               mCnt++;
            end
            thr = (mDeb == 0) ? 1 : int'(mDeb);
            if (mCnt >= thr && mCand != mStable) begin
               mPendP |= mCand & ~mStable;
               if (mRelEn) mPendR |= mStable & ~mCand;
               mStable = mCand;
            end
         end
         flush = wr && (addr == 2'd0) && wdata[31];
         if (flush) begin
            mQ.delete();
            mPendP = '0;
            mPendR = '0;
            mOvf   = 0;
         end else begin
            oldSize = mQ.size();
            if (popped) void'(mQ.pop_front());
            if (wr && addr == 2'd1 && wdata[2]) mOvf = 0;
            if (emit) begin
               if (oldSize == 16 && !popped) mOvf = 1;
               else mQ.push_back(word);
            end
         end
         if (wr && addr == 2'd0) begin
            mIrqEn = wdata[0];
            mRelEn = wdata[1];
            mDeb   = wdata[7:4];
         end
         mIrq = nextIrq;
      end
   end

   // Every cycle, away from the active edge, the DUT must agree with the model.
   always @(negedge clk) begin
      if (chkOn) begin
         checkOutput("cyc_readdata", rdata, mRd);
         checkOutput("cyc_irq", {31'd0, irq}, {31'd0, mIrq});
      end
   end

   task automatic applyStimulus(input logic [15:0] s, input logic sd, input logic w,
                                input logic r, input logic [1:0] a, input logic [31:0] d);
      scan_state = s;
      scan_done  = sd;
      wr         = w;
      rd         = r;
      addr       = a;
      wdata      = d;
      @(posedge clk);
      #2;
      scan_done  = 1'b0;
      wr         = 1'b0;
      rd         = 1'b0;
   endtask

   task automatic scan(input logic [15:0] s);
      curScan = s;
      applyStimulus(s, 1'b1, 1'b0, 1'b0, 2'd0, 32'd0);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) applyStimulus(curScan, 1'b0, 1'b0, 1'b0, 2'd0, 32'd0);
   endtask

   task automatic busWrite(input logic [1:0] a, input logic [31:0] d);
      applyStimulus(curScan, 1'b0, 1'b1, 1'b0, a, d);
   endtask

   task automatic busRead(input logic [1:0] a);
      applyStimulus(curScan, 1'b0, 1'b0, 1'b1, a, 32'd0);
   endtask

   task automatic doReset();
      curScan    = '0;
      scan_state = '0;
      rst = 1'b1;
      @(posedge clk);
      #2;
      rst = 1'b0;
   endtask

   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int          r;
      logic        sd, w, rdv;
      logic [1:0]  a;
      logic [31:0] d;

      #1 rst = 1'b1;
      #1 chkOn = 1'b1;
      #19 rst = 1'b0;
      @(posedge clk);
      #2;
      checkOutput("reset_readdata", rdata, 32'd0);
      checkOutput("reset_irq", {31'd0, irq}, 32'd0);
      busRead(2'd1);
      checkOutput("reset_status", rdata, 32'h0000_0001);

      // Key 5 held for three scans with a threshold of three.
      busWrite(2'd0, 32'h0000_0031);
      scan(16'h0020); scan(16'h0020); scan(16'h0020);
      busRead(2'd3);
      checkOutput("held_stable", rdata, 32'h0000_0020);
      busRead(2'd2);
      checkOutput("held_event", rdata, 32'hC000_0005);
      checkOutput("held_irq_before_pop", {31'd0, irq}, 32'd1);
      idle(1);
      checkOutput("held_irq_after_pop", {31'd0, irq}, 32'd0);

      // Silent release, then a bouncing press that settles.
      scan(16'h0000); scan(16'h0000); scan(16'h0000);
      scan(16'h0020); scan(16'h0000); scan(16'h0020); scan(16'h0020); scan(16'h0020);
      idle(2);
      busRead(2'd1);
      checkOutput("bounce_level", rdata, 32'h0000_0100);
      busRead(2'd2);
      checkOutput("bounce_event", rdata, 32'hC000_0005);
      busRead(2'd2);
      checkOutput("bounce_empty_read", rdata, 32'd0);

      // Two keys pressed and released together with releases enabled.
      doReset();
      busWrite(2'd0, 32'h0000_0013);
      scan(16'h0204);
      idle(3);
      scan(16'h0000);
      idle(3);
      busRead(2'd2); checkOutput("pair_ev0", rdata, 32'hC000_0002);
      busRead(2'd2); checkOutput("pair_ev1", rdata, 32'hC000_0009);
      busRead(2'd2); checkOutput("pair_ev2", rdata, 32'h8000_0002);
      busRead(2'd2); checkOutput("pair_ev3", rdata, 32'h8000_0009);
      busRead(2'd2); checkOutput("pair_ev4", rdata, 32'h0000_0000);

      // Twenty presses into a sixteen-entry queue.
      doReset();
      busWrite(2'd0, 32'h0000_0011);
      for (int i = 0; i < 20; i++) begin
         scan(16'h0001);
         scan(16'h0000);
      end
      busRead(2'd1);
      checkOutput("ovf_status", rdata, 32'h0000_1006);
      busWrite(2'd1, 32'h0000_0004);
      busRead(2'd1);
      checkOutput("ovf_cleared_status", rdata, 32'h0000_1002);
      checkOutput("ovf_irq_held", {31'd0, irq}, 32'd1);
      for (int i = 0; i < 16; i++) begin
         busRead(2'd2);
         checkOutput("ovf_drain", rdata, 32'hC000_0000);
      end
      idle(2);
      checkOutput("ovf_irq_drained", {31'd0, irq}, 32'd0);
      busRead(2'd1);
      checkOutput("ovf_drained_status", rdata, 32'h0000_0001);

      // Pop and push on the same edge while full.
      doReset();
      busWrite(2'd0, 32'h0000_0011);
      for (int i = 0; i < 16; i++) begin
         scan(16'h0001);
         scan(16'h0000);
      end
      scan(16'h0001);
      busRead(2'd2);
      checkOutput("fullpp_event", rdata, 32'hC000_0000);
      busRead(2'd1);
      checkOutput("fullpp_status", rdata, 32'h0000_1002);

      // Flush while the encoder is still draining a burst.
      doReset();
      busWrite(2'd0, 32'h0000_0011);
      scan(16'hFFFF);
      idle(1);
      busWrite(2'd0, 32'h8000_0011);
      busRead(2'd1);
      checkOutput("flush_status", rdata, 32'h0000_0001);
      idle(3);
      busRead(2'd1);
      checkOutput("flush_status_later", rdata, 32'h0000_0001);
      busRead(2'd0);
      checkOutput("flush_ctrl_readback", rdata, 32'h0000_0011);

      // Asynchronous reset while a scan is being taken.
      scan(16'h0000);
      scan(16'h0003);
      idle(3);
      checkOutput("prereset_irq", {31'd0, irq}, 32'd1);
      busRead(2'd3);
      checkOutput("prereset_stable", rdata, 32'h0000_0003);
      curScan    = 16'h0010;
      scan_state = 16'h0010;
      scan_done  = 1'b1;
      @(posedge clk);
      #3;
      rst = 1'b1;
      #1;
      checkOutput("async_reset_readdata", rdata, 32'd0);
      checkOutput("async_reset_irq", {31'd0, irq}, 32'd0);
      scan_done = 1'b0;
      @(posedge clk);
      #2;
      rst = 1'b0;

      // Randomized traffic against the model.
      busWrite(2'd0, {24'd0, 4'($urandom_range(0, 3)), 2'b00, 1'b1, 1'($urandom)});
      for (int c = 0; c < 4000; c++) begin
         if ($urandom_range(0, 9) == 0) begin
            if ($urandom_range(0, 7) == 0) curScan = 16'($urandom);
            else curScan = {12'd0, 4'($urandom)};
         end
         sd  = ($urandom_range(0, 2) == 0);
         r   = $urandom_range(0, 99);
         w   = 1'b0;
         rdv = 1'b0;
         a   = 2'd0;
         d   = 32'd0;
         if (r < 12) begin
            rdv = 1'b1;
            a   = 2'($urandom_range(0, 3));
         end else if (r < 14) begin
            w = 1'b1;
            a = 2'd0;
            d = {1'($urandom_range(0, 15) == 0), 23'd0, 4'($urandom_range(0, 3)), 2'b00, 2'($urandom)};
         end else if (r < 16) begin
            w = 1'b1;
            a = 2'd1;
            d = $urandom;
         end
         applyStimulus(curScan, sd, w, rdv, a, d);
      end
      idle(2);

      $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
      $finish;
   end

endmodule
